// File: rtl/uart_transmit_fsm.sv
// UART transmit serialiser. It sends a start bit, 5-8 data bits LSB first, an optional parity bit
// and 1 or 2 stop bits, and it can hold the line low for a break. Bit timing comes from bit_edge.
module uart_transmit_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  utten,
    input  logic                  bit_edge,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    input  logic [1:0]            wls,
    input  logic                  pen,
    input  logic                  eps,
    input  logic                  stb,
    input  logic                  tx_break,
    output logic                  uart_txd,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      r_word_len;
    logic                  r_pen;
    logic                  r_stb;
    logic                  r_parity;
    logic                  r_stop_cnt;
    logic                  r_txd;
    logic                  r_done;

    logic [CNT_W-1:0]      w_word_len;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_data_masked;
    logic                  w_parity;
    logic                  w_last_stop;
    logic                  w_accept;

    // Word length decode and the mask of the bits that belong to the character
    always_comb begin
        w_word_len = CNT_W'(5) + CNT_W'(wls);
        w_mask     = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            w_mask[i] = (CNT_W'(i) < w_word_len);
        end
        w_data_masked = tx_data & w_mask;
    end

    // The parity bit is computed when the character is accepted, so only the bit needs storing
    assign w_parity    = eps ? (^w_data_masked) : ~(^w_data_masked);
    assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == r_stb);
    assign w_accept    = bit_edge & utten & tx_valid & ~tx_break & ~preset
                       & ((r_state == S_IDLE) | w_last_stop);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_word_len <= '0;
            r_pen      <= 1'b0;
            r_stb      <= 1'b0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bit_edge) begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_break) begin
                            r_state <= S_BREAK;
                            r_txd   <= 1'b0;
                        end else begin
                            r_txd   <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state   <= S_DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= CNT_W'(1);
                    end
                    S_DATA: begin
                        if (r_bit_cnt == r_word_len) begin
                            if (r_pen) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_parity;
                            end else begin
                                r_state    <= S_STOP;
                                r_txd      <= 1'b1;
                                r_stop_cnt <= 1'b0;
                            end
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        r_state    <= S_STOP;
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b0;
                    end
                    S_STOP: begin
                        if (w_last_stop) begin
                            r_done <= 1'b1;
                            if (tx_break) begin
                                r_state <= S_BREAK;
                                r_txd   <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                            r_txd      <= 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (tx_break) begin
                            r_txd <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase

                // Acceptance overrides the idle/stop outcome above: load and go straight to START
                if (w_accept) begin
                    r_state    <= S_START;
                    r_txd      <= 1'b0;
                    r_shift    <= w_data_masked;
                    r_word_len <= w_word_len;
                    r_pen      <= pen;
                    r_stb      <= stb;
                    r_parity   <= w_parity;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                end
            end
        end
    end

    assign tx_ready = w_accept;
    assign uart_txd = r_txd;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_transmit_fsm.sv
// Bench for uart_transmit_fsm: directed frames with hand-computed line bits pushed to a queue,
// and a monitor that samples the line once per bit period and compares against the queue.
module tb_uart_transmit_fsm;

    logic       pclk;
    logic       preset;
    logic       utten;
    logic       bit_edge;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       stb;
    logic       tx_break;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;

    int vectors     = 0;
    int miscompares = 0;
    int ready_cnt   = 0;
    int done_cnt    = 0;
    int busy_cyc    = 0;
    int r0          = 0;
    int d0          = 0;
    int b0          = 0;
    int be_cnt      = 0;

    logic exp_q[$];
    logic be_seen = 1'b0;
    logic cur_bit = 1'b1;
    logic mon_en  = 1'b0;

    uart_transmit_fsm #(.DATA_WIDTH(8)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .utten    (utten),
        .bit_edge (bit_edge),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .wls      (wls),
        .pen      (pen),
        .eps      (eps),
        .stb      (stb),
        .tx_break (tx_break),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // One bit_edge every 16 pclk, changed 2 time units after the rising edge
    initial begin
        bit_edge = 1'b0;
        forever begin
            @(posedge pclk);
            #2;
            be_cnt   = (be_cnt == 15) ? 0 : be_cnt + 1;
            bit_edge = (be_cnt == 15);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i) == 8'h31);
    endtask

    task automatic snap();
        r0 = ready_cnt;
        d0 = done_cnt;
        b0 = busy_cyc;
    endtask

    // Returns just after a rising edge at which bit_edge was high
    task automatic wait_be();
        int n;
        n = 0;
        forever begin
            @(posedge pclk);
            if (bit_edge) break;
            n++;
            if (n > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_be: no bit_edge within %0d cycles (t=%0t)", n, $time);
                break;
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 600) begin
            @(posedge pclk);
            #1;
            n++;
        end
        if (tx_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: still busy after %0d cycles (t=%0t)", n, $time);
        end
        @(negedge pclk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
        wls = w;
        pen = p;
        eps = e;
        stb = s;
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_be();
        tx_valid = 1'b0;
    endtask

    // Monitor: one line sample per bit period, steady-line check in between
    always @(negedge pclk) begin
        if (mon_en) begin
            if (tx_ready) ready_cnt++;
            if (tx_done)  done_cnt++;
            if (tx_busy)  busy_cyc++;
            if (be_seen) begin
                if (tx_busy) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL txd_extra: busy bit with empty queue, txd=%0b (t=%0t)", uart_txd, $time);
                    end else begin
                        cur_bit = exp_q.pop_front();
                        check("txd_bit", 32'(uart_txd), 32'(cur_bit));
                    end
                end else begin
                    check("txd_idle", 32'(uart_txd), 32'd1);
                end
            end else if (tx_busy) begin
                check("txd_hold", 32'(uart_txd), 32'(cur_bit));
            end
        end
        be_seen = bit_edge;
    end

    initial begin
        preset   = 1'b1;
        utten    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_break = 1'b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        check("rst_txd",   32'(uart_txd), 32'd1);
        check("rst_busy",  32'(tx_busy),  32'd0);
        check("rst_done",  32'(tx_done),  32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        @(posedge pclk);
        #1;
        preset = 1'b0;
        mon_en = 1'b1;

        // 8N1 0xA5
        snap();
        push_str("0101001011");
        send(8'hA5);
        wait_idle();
        check("a5_busy_cycles", 32'(busy_cyc - b0),  32'd160);
        check("a5_done",        32'(done_cnt - d0),  32'd1);
        check("a5_ready",       32'(ready_cnt - r0), 32'd1);

        // 7E1 0xC1 (bit 7 ignored), then 5O2 0xFF (bits 7:5 ignored)
        snap();
        cfg(2'b10, 1'b1, 1'b1, 1'b0);
        push_str("0100000101");
        send(8'hC1);
        wait_idle();
        cfg(2'b00, 1'b1, 1'b0, 1'b1);
        push_str("011111011");
        send(8'hFF);
        wait_idle();
        check("7e1_5o2_done", 32'(done_cnt - d0), 32'd2);

        // Back-to-back 0x55 then 0xAA, tx_valid held
        snap();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        push_str("0101010101");
        push_str("0010101011");
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        wait_be();
        tx_data = 8'hAA;
        repeat (10) wait_be();
        tx_valid = 1'b0;
        wait_idle();
        check("b2b_ready",       32'(ready_cnt - r0), 32'd2);
        check("b2b_done",        32'(done_cnt - d0),  32'd2);
        check("b2b_busy_cycles", 32'(busy_cyc - b0),  32'd320);

        // Break raised during DATA of 0x00, with 0x3C pending under the break
        snap();
        push_str("0000000001");
        push_str("000");
        push_str("0001111001");
        send(8'h00);
        repeat (3) wait_be();
        tx_break = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (7) wait_be();
        check("brk_entered_txd",  32'(uart_txd), 32'd0);
        check("brk_entered_busy", 32'(tx_busy),  32'd1);
        repeat (2) wait_be();
        tx_break = 1'b0;
        wait_be();
        check("brk_exit_txd",  32'(uart_txd), 32'd1);
        check("brk_exit_busy", 32'(tx_busy),  32'd0);
        check("brk_pending",   32'(ready_cnt - r0), 32'd1);
        wait_be();
        tx_valid = 1'b0;
        wait_idle();
        check("brk_ready", 32'(ready_cnt - r0), 32'd2);
        check("brk_done",  32'(done_cnt - d0),  32'd2);

        // utten low blocks acceptance; dropping it mid-frame lets the frame finish
        snap();
        utten    = 1'b0;
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        repeat (4) wait_be();
        check("uten_off_ready", 32'(ready_cnt - r0), 32'd0);
        check("uten_off_busy",  32'(tx_busy),        32'd0);
        push_str("0010010001");
        utten = 1'b1;
        wait_be();
        repeat (3) wait_be();
        utten = 1'b0;
        wait_idle();
        repeat (3) wait_be();
        check("uten_mid_ready", 32'(ready_cnt - r0), 32'd1);
        check("uten_mid_busy",  32'(tx_busy),        32'd0);
        tx_valid = 1'b0;
        utten    = 1'b1;

        // Reset mid-DATA of 0x96, then 8O1 0x5A with config changed mid-frame
        snap();
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        push_str("0011010011");
        send(8'h96);
        repeat (2) wait_be();
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b1;
        exp_q.delete();
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        check("mid_rst_txd",  32'(uart_txd), 32'd1);
        check("mid_rst_busy", 32'(tx_busy),  32'd0);
        check("mid_rst_done", 32'(tx_done),  32'd0);
        snap();
        cfg(2'b11, 1'b1, 1'b0, 1'b0);
        push_str("00101101011");
        send(8'h5A);
        repeat (2) wait_be();
        cfg(2'b00, 1'b0, 1'b1, 1'b1);
        tx_data = 8'hFF;
        wait_idle();
        check("post_rst_done",        32'(done_cnt - d0), 32'd1);
        check("post_rst_busy_cycles", 32'(busy_cyc - b0), 32'd176);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
